// File: rtl/freq_meter.sv
// Frequency meter: counts synchronized rising edges of SigIn over a fixed
// window of GATE_CYCLES CLKIn cycles and publishes the count with a Valid strobe.
//
// state   | meaning
// IDLE    | counters held at 0, waiting for Enable
// MEASURE | gate window running, rising edges counted (saturating)
// DONE    | one cycle: Valid high, Result/Overflow hold the new window, counters cleared
module freq_meter #(
  parameter int GATE_CYCLES = 50000000,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 CLKIn,
  input  logic                 Reset,
  input  logic                 SigIn,
  input  logic                 Enable,
  output logic [CNT_WIDTH-1:0] Result,
  output logic                 Valid,
  output logic                 Overflow
);

  localparam int GW = $clog2(GATE_CYCLES) + 1;
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, MEASURE, DONE} state_t;

  state_t               state, state_nxt;
  logic                 s1, s2, s3;
  logic                 rise;
  logic                 last_cycle;
  logic [GW-1:0]        gate_cnt;
  logic [CNT_WIDTH-1:0] edge_cnt, edge_nxt;
  logic                 sat, sat_nxt;

  // SigIn is asynchronous: two flops to resolve metastability, a third for edge detect.
  always_ff @(posedge CLKIn) begin
    if (Reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= SigIn;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise       = s2 & ~s3;
  assign last_cycle = (gate_cnt == GATE_LAST);
  assign Valid      = (state == DONE);

  always_ff @(posedge CLKIn) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Enable) state_nxt = MEASURE;
      MEASURE: begin
        if (!Enable)         state_nxt = IDLE;
        else if (last_cycle) state_nxt = DONE;
      end
      DONE:    state_nxt = Enable ? MEASURE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Saturating edge count; a rise arriving at all-ones marks the window as overflowed.
  always_comb begin
    edge_nxt = edge_cnt;
    sat_nxt  = sat;
    if (rise) begin
      if (&edge_cnt) sat_nxt  = 1'b1;
      else           edge_nxt = edge_cnt + CNT_WIDTH'(1);
    end
  end

  // Result is loaded on entry to DONE so it is already valid while Valid is high.
  always_ff @(posedge CLKIn) begin
    if (Reset) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      sat      <= 1'b0;
      Result   <= '0;
      Overflow <= 1'b0;
    end else begin
      case (state)
        MEASURE: begin
          if (!Enable) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
          end else begin
            gate_cnt <= gate_cnt + GW'(1);
            edge_cnt <= edge_nxt;
            sat      <= sat_nxt;
            if (last_cycle) begin
              Result   <= edge_nxt;
              Overflow <= sat_nxt;
            end
          end
        end
        default: begin
          gate_cnt <= '0;
          edge_cnt <= '0;
          sat      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: two instances (32-bit and 4-bit counters) share stimulus and
// are compared every cycle against a window-level model using unbounded integer counts.
module tb_freq_meter;

  localparam int G = 100;

  logic        CLKIn = 1'b0;
  logic        Reset, SigIn, Enable;
  logic [31:0] result_a;
  logic        valid_a, ovf_a;
  logic [3:0]  result_b;
  logic        valid_b, ovf_b;

  freq_meter #(.GATE_CYCLES(G), .CNT_WIDTH(32)) dut_a (
    .CLKIn(CLKIn), .Reset(Reset), .SigIn(SigIn), .Enable(Enable),
    .Result(result_a), .Valid(valid_a), .Overflow(ovf_a));

  freq_meter #(.GATE_CYCLES(G), .CNT_WIDTH(4)) dut_b (
    .CLKIn(CLKIn), .Reset(Reset), .SigIn(SigIn), .Enable(Enable),
    .Result(result_b), .Valid(valid_b), .Overflow(ovf_b));

  always #10 CLKIn = ~CLKIn;

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: phase -1 idle, 0..G-1 window position, G = publish cycle.
  int          m_phase = -1;
  longint      m_total = 0;
  logic [31:0] m_res_a = '0;
  logic [3:0]  m_res_b = '0;
  bit          m_ovf_a = 0, m_ovf_b = 0;
  bit          m_known = 0;
  bit          hist [3];

  task automatic model_step(input bit rst, input bit en, input bit sig);
    bit r;
    r = hist[1] & ~hist[2];
    if (rst) begin
      m_phase = -1; m_total = 0; m_res_a = '0; m_res_b = '0;
      m_ovf_a = 0; m_ovf_b = 0; m_known = 1;
      hist[0] = 0; hist[1] = 0; hist[2] = 0;
      return;
    end
    hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = sig;
    if (m_phase == -1) begin
      if (en) m_phase = 0;
      m_total = 0;
    end else if (m_phase == G) begin
      m_total = 0;
      m_phase = en ? 0 : -1;
    end else if (!en) begin
      m_phase = -1;
      m_total = 0;
    end else begin
      m_total += r;
      if (m_phase == G - 1) begin
        m_ovf_a = (m_total > 64'hFFFF_FFFF);
        m_res_a = m_ovf_a ? 32'hFFFF_FFFF : m_total[31:0];
        m_ovf_b = (m_total > 15);
        m_res_b = m_ovf_b ? 4'hF : m_total[3:0];
        m_phase = G;
      end else begin
        m_phase++;
      end
    end
  endtask

  int sig_mode = 0;  // 0 constant, 1 periodic, 2 random
  bit sig_const = 0;
  int per = 10, pcnt = 0;
  bit en_drv = 0;
  bit v_seen = 0;

  task automatic gen_sig(output bit s);
    case (sig_mode)
      1: begin s = (pcnt < per / 2); pcnt = (pcnt + 1) % per; end
      2: s = bit'($urandom % 2);
      default: s = sig_const;
    endcase
  endtask

  task automatic tick(input bit rst);
    bit s;
    gen_sig(s);
    Reset = rst; Enable = en_drv; SigIn = s;
    @(negedge CLKIn);
    v_seen = valid_a;
    if (m_known) begin
      check_val("valid_a",  {31'd0, valid_a}, {31'd0, m_phase == G});
      check_val("result_a", result_a, m_res_a);
      check_val("ovf_a",    {31'd0, ovf_a}, {31'd0, m_ovf_a});
      check_val("valid_b",  {31'd0, valid_b}, {31'd0, m_phase == G});
      check_val("result_b", {28'd0, result_b}, {28'd0, m_res_b});
      check_val("ovf_b",    {31'd0, ovf_b}, {31'd0, m_ovf_b});
    end
    @(posedge CLKIn);
    model_step(rst, en_drv, s);
    #1;
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    do begin
      tick(0);
      n++;
    end while (!v_seen && n < max);
    if (!v_seen) check_val("valid_timeout", {31'd0, v_seen}, 32'd1);
  endtask

  initial begin
    int n;
    Reset = 1'b1; Enable = 1'b0; SigIn = 1'b0;
    @(posedge CLKIn); #1;
    tick(1);
    repeat (3) tick(0);

    // periodic input, period 10
    sig_mode = 1; per = 10; pcnt = 0; en_drv = 1;
    wait_valid(300, n);
    wait_valid(300, n);
    check_val("period_101", n, 101);
    check_val("res_p10", result_a, 10);

    // abort mid-window, then restart
    repeat (50) tick(0);
    en_drv = 0;
    repeat (5) tick(0);
    check_val("abort_hold", result_a, 10);
    en_drv = 1;
    wait_valid(300, n);
    check_val("restart_lat", n, 102);

    // saturation on the 4-bit instance, then recovery
    per = 4; pcnt = 0;
    wait_valid(300, n);
    wait_valid(300, n);
    check_val("sat_res_b", {28'd0, result_b}, 15);
    check_val("sat_ovf_b", {31'd0, ovf_b}, 1);
    check_val("p4_res_a", result_a, 25);
    per = 20; pcnt = 0;
    wait_valid(300, n);
    wait_valid(300, n);
    check_val("p20_res_b", {28'd0, result_b}, 5);
    check_val("p20_ovf_b", {31'd0, ovf_b}, 0);

    // input stuck high before Enable rises
    en_drv = 0; sig_mode = 0; sig_const = 1;
    repeat (10) tick(0);
    en_drv = 1;
    wait_valid(300, n);
    wait_valid(300, n);
    check_val("const_period", n, 101);
    check_val("const_res", result_a, 0);

    // synchronous reset mid-window
    sig_mode = 1; per = 10; pcnt = 0;
    repeat (30) tick(0);
    tick(1);
    check_val("rst_result", result_a, 0);
    check_val("rst_valid", {31'd0, valid_a}, 0);
    check_val("rst_ovf", {31'd0, ovf_a}, 0);
    wait_valid(300, n);
    check_val("rst_lat", n, 102);

    // single pulse: rise in last MEASURE cycle, then rise in DONE cycle
    sig_mode = 0; sig_const = 0;
    wait_valid(300, n);
    for (int k = 1; k <= 101; k++) begin sig_const = (k >= 98); tick(0); end
    check_val("pulse_last_valid", {31'd0, v_seen}, 1);
    check_val("pulse_last_res", result_a, 1);
    for (int k = 102; k <= 202; k++) begin sig_const = (k <= 103); tick(0); end
    check_val("pulse_after_res", result_a, 0);
    for (int k = 1; k <= 101; k++) begin sig_const = (k >= 99 && k <= 104); tick(0); end
    check_val("pulse_done_valid", {31'd0, v_seen}, 1);
    check_val("pulse_done_res", result_a, 0);
    sig_const = 0;
    wait_valid(300, n);
    check_val("pulse_done_next", result_a, 0);

    // randomized input, Enable toggling and occasional resets
    sig_mode = 2;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) == 0) en_drv = ~en_drv;
      tick(bit'($urandom_range(0, 499) == 0));
    end
    en_drv = 1;
    for (int i = 0; i < 250; i++) tick(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Measures the frequency of an external digital signal by counting its rising edges over a fixed gate window timed from the 50 MHz board clock.
- It is the inverse of the team's clock divider: that block derives a slow clock from CLKIn; this block recovers how fast an incoming signal toggles, in CLKIn time base.
- Results feed the display/readout logic through a one-cycle Valid strobe.

Parameters:
- GATE_CYCLES, 50000000, gate window length in CLKIn cycles (1 s at 50 MHz); must be >= 2.
- CNT_WIDTH, 32, width of edge counter and Result.

Ports:
- CLKIn  input  1  system clock (50 MHz built-in).
- Reset  input  1  synchronous, active-high reset.
- SigIn  input  1  signal under measurement, asynchronous to CLKIn.
- Enable  input  1  level; 1 = run back-to-back measurements, 0 = idle.
- Result  output  CNT_WIDTH  rising-edge count of the last completed window.
- Valid  output  1  one-cycle pulse when Result updates.
- Overflow  output  1  set when the last completed window saturated.

Behaviour:
- One clock (CLKIn); Reset is synchronous and active-high; every register is updated only on posedge CLKIn.
- Reset values: Result=0, Valid=0, Overflow=0, state=IDLE, gate counter=0, edge counter=0, sync flops=0.
- Input path: SigIn passes through a 2-flop synchronizer (s1, s2), then a third flop s3. Rise = s2 & ~s3.
- Edge latency: a SigIn 0->1 transition meeting setup before edge k gives Rise=1 in the cycle after edge k+1. Rise is counted in that cycle.
- Every state advances the sync chain; Rise is only counted in MEASURE.
- FSM states:
  - IDLE: gate and edge counters held at 0. If Enable=1, go to MEASURE next cycle.
  - MEASURE: gate counter increments each cycle from 0.
    - Edge counter += Rise, saturating at all-ones. A Rise while the counter is at all-ones sets an internal sat flag.
    - When the gate counter == GATE_CYCLES-1 (the last window cycle, so the window is exactly GATE_CYCLES cycles), go to DONE. A Rise in this last cycle is included.
    - Enable=0 in any MEASURE cycle: abort to IDLE. Counters cleared, no Valid, Result/Overflow unchanged.
  - DONE (one cycle):
    - Result <= edge count; Overflow <= sat; Valid=1 in this cycle only.
    - Counters and sat are cleared.
    - Next state is MEASURE if Enable=1, otherwise IDLE.
    - A Rise in the DONE cycle is not counted (one dead cycle per window).
- Valid period with Enable held high: GATE_CYCLES+1 cycles.
- Result and Overflow hold between Valid pulses. They change only in DONE or on Reset.
- Reset asserted mid-window: next cycle all state and outputs are at reset values. No Valid is produced for the partial window.
- Enable toggled while in DONE: the DONE cycle still completes and publishes its result.
- Arithmetic: edge counter is CNT_WIDTH bits, unsigned, saturating (never wraps). Gate counter width is ceil(log2(GATE_CYCLES))+1 bits.
- Frequency in Hz = Result * CLK_HZ / GATE_CYCLES. This scaling is done by the consumer, not this block.

Test Plan:
- GATE_CYCLES=100, CNT_WIDTH=32, SigIn period 10 cycles (5 high/5 low), Enable held high -> Valid every 101 cycles; Result=10 (±1 on the first window depending on phase); Overflow=0.
- SigIn held constant 1 from before Enable rises -> every window reports Result=0, with Valid still at the 101-cycle period.
- CNT_WIDTH=4, GATE_CYCLES=100, SigIn period 4 -> Result=15 (saturated), Overflow=1. Then SigIn period 20 -> next Result=5, Overflow=0.
- Enable dropped at cycle 50 of a window after a prior Result=10 -> no Valid; Result stays 10. Re-raising Enable gives the first Valid 102 cycles later (1 IDLE + 100 MEASURE + DONE).
- Reset pulsed for one cycle mid-window -> next cycle Result=0, Valid=0, Overflow=0, state IDLE. With Enable=1, measurement restarts and the first Valid arrives 102 cycles after Reset deasserts.
- Single SigIn pulse timed so Rise lands in the last MEASURE cycle -> Result=1. The same pulse shifted so Rise lands in the DONE cycle -> Result=0 for both that window and the next.
